// File: rtl/root_pkg.sv
// Shared definitions for the k-th root request dispatcher: operand and result
// widths, the Q10.10 value 1.0 used for degree-0 bypass, and FSM encoding.
package root_pkg;

    localparam int RADICAND_W = 10;
    localparam int DEGREE_W   = 3;
    localparam int RESULT_W   = 20;

    localparam logic [RESULT_W-1:0] ONE_Q10_10 = 20'h00400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/root_req_fifo.sv
// Request FIFO holding {radicand, degree, tag}. The head entry is visible
// combinationally so the dispatcher can inspect it before committing, and it
// stays put until the dispatcher pops it on the response handshake.
module root_req_fifo
    import root_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [RADICAND_W-1:0] push_radicand,
    input  logic [DEGREE_W-1:0]   push_degree,
    input  logic [TAG_W-1:0]      push_tag,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [RADICAND_W-1:0] head_radicand,
    output logic [DEGREE_W-1:0]   head_degree,
    output logic [TAG_W-1:0]      head_tag
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = RADICAND_W + DEGREE_W + TAG_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_radicand, push_degree, push_tag};
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign {head_radicand, head_degree, head_tag} = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/root_dispatcher.sv
// Feeds queued root requests one at a time to the k-th root engine, holds the
// operands for the whole computation and returns results in request order.
// Degree-0 requests are answered with 1.0 without touching the engine.
module root_dispatcher
    import root_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [RADICAND_W-1:0] req_radicand,
    input  logic [DEGREE_W-1:0]   req_degree,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  root_in_valid,
    output logic [RADICAND_W-1:0] root_data_1,
    output logic [DEGREE_W-1:0]   root_data_2,
    input  logic                  root_out_valid,
    input  logic [RESULT_W-1:0]   root_out_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RESULT_W-1:0]   rsp_root,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_bypass,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic [RADICAND_W-1:0] root_data_1_q, root_data_1_d;
    logic [DEGREE_W-1:0]   root_data_2_q, root_data_2_d;
    logic [RESULT_W-1:0]   rsp_root_q, rsp_root_d;
    logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
    logic                  rsp_bypass_q, rsp_bypass_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [RADICAND_W-1:0] head_radicand;
    logic [DEGREE_W-1:0]   head_degree;
    logic [TAG_W-1:0]      head_tag;

    // No pass-through when full: a pop this cycle does not free a slot until next.
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    // The head stays queued while in flight so responses remain in order.
    assign fifo_pop  = (state_q == ST_RESP) && rsp_ready;

    root_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (fifo_push),
        .push_radicand (req_radicand),
        .push_degree   (req_degree),
        .push_tag      (req_tag),
        .pop           (fifo_pop),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .head_radicand (head_radicand),
        .head_degree   (head_degree),
        .head_tag      (head_tag)
    );

    // Next-state and operand/response register updates.
    always_comb begin
        state_d       = state_q;
        root_data_1_d = root_data_1_q;
        root_data_2_d = root_data_2_q;
        rsp_root_d    = rsp_root_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_bypass_d  = rsp_bypass_q;
        unique case (state_q)
            ST_IDLE: begin
                // A lingering engine valid from the previous job must drop first.
                if (!fifo_empty && !root_out_valid) begin
                    rsp_tag_d = head_tag;
                    if (head_degree == '0) begin
                        rsp_root_d   = ONE_Q10_10;
                        rsp_bypass_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        root_data_1_d = head_radicand;
                        root_data_2_d = head_degree;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (root_out_valid) begin
                    rsp_root_d   = root_out_data;
                    rsp_bypass_d = 1'b0;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            root_data_1_q <= '0;
            root_data_2_q <= '0;
            rsp_root_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_bypass_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            root_data_1_q <= root_data_1_d;
            root_data_2_q <= root_data_2_d;
            rsp_root_q    <= rsp_root_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_bypass_q  <= rsp_bypass_d;
        end
    end

    assign root_in_valid = (state_q == ST_ISSUE);
    assign root_data_1   = root_data_1_q;
    assign root_data_2   = root_data_2_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_root      = rsp_root_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_bypass    = rsp_bypass_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule
